// File: rtl/jtag_axi_pkg.sv
// Shared definitions for the JTAG-AXI register slave: response codes, register map,
// channel FSM state types and the byte-strobe merge helper.
package jtag_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] REG_CONTROL = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_DATA    = 4'h8;
   localparam logic [3:0] REG_TEST    = 4'hC;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Replace only the bytes of old_val whose strobe bit is set.
   function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/jtag_axi_reg_slave.sv
// AXI4-Lite register slave: CONTROL/DATA/TEST RW registers, read-only STATUS view,
// independent write and read channel FSMs, and B/R handshake counters on debug_gpio.
module jtag_axi_reg_slave
   import jtag_axi_pkg::*;
#(
   parameter int unsigned                AXI_ADDR_WIDTH = 32,
   parameter int unsigned                AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h43C00000)
) (
   input  logic                      sys_clk,
   input  logic                      sys_reset,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [31:0]               s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [31:0]               s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [31:0]               ext_status_reg,
   output logic [31:0]               control_reg_out,
   output logic [31:0]               data_reg_out,
   output logic [31:0]               test_reg_out,
   output logic                      interrupt_out,
   output logic [7:0]                debug_gpio
);

   localparam int unsigned AW = AXI_ADDR_WIDTH;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   if (AXI_DATA_WIDTH != DW) begin : g_dw_check
      $error("jtag_axi_reg_slave supports only AXI_DATA_WIDTH = 32");
   end
   if (AW <= 4) begin : g_aw_check
      $error("jtag_axi_reg_slave requires AXI_ADDR_WIDTH > 4");
   end
   if (BASE_ADDR[3:0] != 4'h0) begin : g_base_check
      $error("jtag_axi_reg_slave BASE_ADDR must be 16-byte aligned");
   end

   wr_state_t         wr_state_q, wr_state_d;
   rd_state_t         rd_state_q, rd_state_d;
   logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [AW-1:0]     aw_addr_q, aw_addr_d;
   logic [DW-1:0]     w_data_q, w_data_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [DW-1:0]     control_q, control_d, data_q, data_d, test_q, test_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic              aw_hs, w_hs, ar_hs;
   logic [1:0]        wr_resp, rd_resp;
   logic [3:0]        wr_off, rd_off;
   logic [DW-1:0]     rd_val;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{aw_addr_q[1:0], s_axi_araddr[1:0]};

   // Window hit check; writes to the read-only STATUS slot are rejected.
   function automatic logic [1:0] decode_resp(input logic [AW-1:0] addr, input logic is_write);
      if (addr[AW-1:4] != BASE_ADDR[AW-1:4]) return RESP_SLVERR;
      if (is_write && ({addr[3:2], 2'b00} == REG_STATUS)) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   // Next-state and registered-output logic for both channels.
   always_comb begin
      wr_state_d = wr_state_q;
      rd_state_d = rd_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      control_d  = control_q;
      data_d     = data_q;
      test_d     = test_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      wr_resp    = RESP_OKAY;
      rd_resp    = RESP_OKAY;
      wr_off     = 4'h0;
      rd_off     = {s_axi_araddr[3:2], 2'b00};
      rd_val     = '0;
      aw_hs      = s_axi_awvalid && awready_q;
      w_hs       = s_axi_wvalid && wready_q;
      ar_hs      = s_axi_arvalid && arready_q;

      if (wr_state_q == W_IDLE) begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
         end
         // Commit on the edge where the later of AW/W arrives.
         if (aw_held_d && w_held_d) begin
            wr_resp    = decode_resp(aw_addr_d, 1'b1);
            wr_off     = {aw_addr_d[3:2], 2'b00};
            bresp_d    = wr_resp;
            bvalid_d   = 1'b1;
            wr_state_d = W_RESP;
            if (wr_resp == RESP_OKAY) begin
               case (wr_off)
                  REG_CONTROL: control_d = wstrb_merge(control_q, w_data_d, w_strb_d);
                  REG_DATA:    data_d    = wstrb_merge(data_q, w_data_d, w_strb_d);
                  REG_TEST:    test_d    = wstrb_merge(test_q, w_data_d, w_strb_d);
                  default:     ;
               endcase
            end
         end
      end else if (s_axi_bready) begin
         bvalid_d   = 1'b0;
         aw_held_d  = 1'b0;
         w_held_d   = 1'b0;
         wr_cnt_d   = wr_cnt_q + CW'(1);
         wr_state_d = W_IDLE;
      end

      case (rd_off)
         REG_CONTROL: rd_val = control_q;
         REG_STATUS:  rd_val = ext_status_reg;
         REG_DATA:    rd_val = data_q;
         REG_TEST:    rd_val = test_q;
         default:     rd_val = '0;
      endcase

      if (rd_state_q == R_IDLE) begin
         if (ar_hs) begin
            rd_resp    = decode_resp(s_axi_araddr, 1'b0);
            rresp_d    = rd_resp;
            rdata_d    = (rd_resp == RESP_OKAY) ? rd_val : '0;
            rvalid_d   = 1'b1;
            rd_state_d = R_DATA;
         end
      end else if (s_axi_rready) begin
         rvalid_d   = 1'b0;
         rd_cnt_d   = rd_cnt_q + CW'(1);
         rd_state_d = R_IDLE;
      end

      awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
      wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
      arready_d = (rd_state_d == R_IDLE);
   end

   // State and output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b1;
         arready_q  <= 1'b1;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         control_q  <= '0;
         data_q     <= '0;
         test_q     <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         arready_q  <= arready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         control_q  <= control_d;
         data_q     <= data_d;
         test_q     <= test_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   assign s_axi_awready   = awready_q;
   assign s_axi_wready    = wready_q;
   assign s_axi_arready   = arready_q;
   assign s_axi_bvalid    = bvalid_q;
   assign s_axi_bresp     = bresp_q;
   assign s_axi_rvalid    = rvalid_q;
   assign s_axi_rresp     = rresp_q;
   assign s_axi_rdata     = rdata_q;
   assign control_reg_out = control_q;
   assign data_reg_out    = data_q;
   assign test_reg_out    = test_q;
   assign interrupt_out   = control_q[0];
   assign debug_gpio      = {rd_cnt_q, wr_cnt_q};

endmodule

// File: doc/jtag_axi_reg_slave.md
Name: jtag_axi_reg_slave

Overview:
AXI4-Lite responder (slave) register file at the far end of the JTAG-to-AXI master bridge inside the JTAG-AXI top. It decodes transactions at BASE_ADDR and holds CONTROL, DATA and TEST registers plus a read-only STATUS view. It drives the register outputs, interrupt_out and debug_gpio. Out-of-window or illegal accesses complete with SLVERR and change no state.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width.
AXI_DATA_WIDTH, 32, data width; only 32 is supported (elaboration error otherwise).
BASE_ADDR, 32'h43C00000, window base; must be 16-byte aligned.

Ports:
sys_clk  in  1  single clock.
sys_reset  in  1  reset; synchronous and active-high.
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte strobes.
s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
s_axi_bresp  out  2  write response.
s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
ext_status_reg  in  32  live status value, readable at offset 0x04.
control_reg_out, data_reg_out, test_reg_out  out  32  register contents.
interrupt_out  out  1  equals control_reg_out[0].
debug_gpio  out  8  transaction counters.

Behaviour:
- Reset (sys_reset=1 at an edge):
  - All registers, counters and held-address/data flags clear to 0.
  - bvalid, rvalid, bresp, rresp and rdata are 0.
  - awready, wready and arready are 1 from the cycle after reset.
  - Reset mid-transaction discards the transaction; no response is issued.
- Decode:
  - Hit when addr[AW-1:4] == BASE_ADDR[AW-1:4].
  - addr[3:2] selects: 0x00 CONTROL (RW), 0x04 STATUS (RO), 0x08 DATA (RW), 0x0C TEST (RW).
  - addr[1:0] is ignored.
  - Miss gives SLVERR (2'b10); a write to STATUS gives SLVERR; all else gives OKAY (2'b00).
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready = !aw_held and wready = !w_held. Both are driven from flops only, with no input-to-output combinational path.
  - AW and W are accepted in any order or in the same cycle; each is captured on its handshake edge.
  - On the edge where the second of the two completes (or both complete together):
    - For an OKAY access, the target register is updated byte-wise per wstrb.
    - bresp is set and bvalid=1; the FSM moves to W_RESP.
    - Register outputs and bvalid therefore become visible one cycle after the final handshake.
  - In W_RESP, awready=wready=0. bvalid holds, with bresp stable, until bready. On the bready edge the FSM returns to W_IDLE, the held flags clear and the write counter increments.
  - SLVERR writes modify no register.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, arready=1. On the AR handshake edge, rdata and rresp are registered and rvalid=1; the FSM moves to R_DATA.
  - STATUS returns ext_status_reg sampled at that edge. SLVERR returns rdata=0.
  - In R_DATA, arready=0. rvalid, rdata and rresp hold until rready; on that edge the FSM returns to R_IDLE and the read counter increments.
- Write and read channels are independent. A read that samples a register on the same edge a write commits returns the pre-write value.
- debug_gpio[3:0] counts completed B handshakes; debug_gpio[7:4] counts completed R handshakes. Both are 4-bit and wrap 15→0. Error responses are counted.

Decomposition:
- Package jtag_axi_pkg holds:
  - response codes RESP_OKAY / RESP_SLVERR;
  - register offsets REG_CONTROL=0x0, REG_STATUS=0x4, REG_DATA=0x8, REG_TEST=0xC;
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA};
  - a pure function for the wstrb byte merge.
- No sub-module; the two channel FSMs are small enough to live in one module.

Test Plan:
1. Reset, then AW+W in the same cycle to 0x43C00000, data 0x12345678, wstrb 0xF, bready=1 → bvalid one cycle later, bresp=00, control_reg_out=0x12345678, interrupt_out=0, debug_gpio=0x01.
2. W (0xABCDEF00, wstrb 0x5) presented 3 cycles before AW to 0x43C00008 → wready drops after W capture; on the AW handshake data_reg_out=0x00CD0000, OKAY. Then write 0xDEADBEEF to 0x0C → test_reg_out=0xDEADBEEF.
3. ext_status_reg=0x55AA33CC, read 0x43C00004 with rready=1 → rvalid next cycle, rdata=0x55AA33CC, rresp=00. Then write 0x1 to 0x43C00004 → bresp=10, all registers unchanged.
4. Write 0x12345678 to 0x43C00010 and to 0x43C10000; read 0x43C00010 → all bresp/rresp=10, rdata=0, registers unchanged, debug_gpio counts 2 writes and 1 read.
5. Hold bready=0 for 5 cycles after a CONTROL write of 0x1 → bvalid stays high, awready=wready=0, a second pending AW is not accepted, interrupt_out=1; releasing bready completes B, then the second write proceeds.
6. Assert sys_reset for 1 cycle while rvalid=1 and a W is held → next cycle rvalid=bvalid=0, all registers 0, interrupt_out=0, debug_gpio=0x00, all readies 1.
